// File: rtl/md_unit_ctrl_pkg.sv
// md_defs: shared definitions for the multiply/divide unit.
//   - command codes driven on md_unit_ctrl.op
//   - FSM state encoding
//   - default operation latencies
//   - arithmetic result bundle passed from md_arith to the controller
package md_defs;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } md_state_e;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        div_zero;
    } md_result_t;

    // Commands that occupy the unit for a multi-cycle busy period.
    function automatic logic is_long_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit_ctrl_arith.sv
// md_arith: combinational multiply / divide datapath.
//   op       in  3   command code (selects signed/unsigned, mul/div)
//   a, b     in  32  operands (a = rs, b = rt)
//   res      out     {hi, lo, div_zero}
//     mult/multu : hi:lo = 64-bit product
//     div/divu   : lo = quotient, hi = remainder (truncating toward zero)
//     div_zero   : divisor is zero; hi/lo are don't-care in that case
module md_arith
    import md_defs::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output md_result_t  res
);

    logic        is_signed;
    logic [63:0] a_ext, b_ext, prod;
    logic [31:0] dsor, mag_a, mag_b, q_m, r_m;
    logic        neg_a, neg_b;

    assign is_signed = (op == MD_MULT) || (op == MD_DIV);

    // Low 64 bits of the product of the 64-bit extended operands give the
    // signed or unsigned result depending on the extension used.
    assign a_ext = is_signed ? {{32{a[31]}}, a} : {32'b0, a};
    assign b_ext = is_signed ? {{32{b[31]}}, b} : {32'b0, b};
    assign prod  = a_ext * b_ext;

    // Divide on magnitudes so 0x80000000 / -1 needs no special case:
    // |a| = 0x80000000 as unsigned, quotient sign is positive, and the
    // 32-bit result wraps to 0x80000000 with remainder 0.
    assign dsor  = (b == 32'd0) ? 32'd1 : b;
    assign neg_a = is_signed & a[31];
    assign neg_b = is_signed & dsor[31];
    assign mag_a = neg_a ? (32'd0 - a)    : a;
    assign mag_b = neg_b ? (32'd0 - dsor) : dsor;
    assign q_m   = mag_a / mag_b;
    assign r_m   = mag_a % mag_b;

    always_comb begin
        res          = '0;
        res.div_zero = (b == 32'd0);
        if ((op == MD_DIV) || (op == MD_DIVU)) begin
            res.lo = (neg_a ^ neg_b) ? (32'd0 - q_m) : q_m;
            res.hi = neg_a ? (32'd0 - r_m) : r_m;
        end else begin
            res.hi = prod[63:32];
            res.lo = prod[31:0];
        end
    end

endmodule

// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: multi-cycle multiply/divide controller with HI/LO pair.
//   clk, reset  in   clock, synchronous active-high reset
//   start, op   in   command issue from E stage
//   src_a/b     in   forwarded rs/rt values
//   d_md_use    in   D-stage instruction touches the unit
//   busy        out  operation in progress
//   stall_md    out  stall request to the hazard controller
//   hi, lo      out  architectural HI/LO registers
// Results are computed at acceptance and held in pend_* until the busy
// counter expires, which models the fixed latency of a real divider.
module md_unit_ctrl
    import md_defs::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        d_md_use,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    md_state_e        state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      pend_hi, pend_lo;
    logic             pend_we;   // cleared on div-by-zero: commit is skipped
    logic             accept;
    logic             done;
    md_result_t       ar;

    md_arith u_arith (
        .op  (op),
        .a   (src_a),
        .b   (src_b),
        .res (ar)
    );

    assign accept = (state == S_IDLE) && start;
    assign done   = (state == S_BUSY) && (cnt == CNT_ONE);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start && is_long_op(op)) state_nx = S_BUSY;
            S_BUSY: if (cnt == CNT_ONE)          state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs: a long op being started this cycle already stalls D.
    always_comb begin
        busy     = (state == S_BUSY);
        stall_md = d_md_use & (busy | (start & is_long_op(op)));
    end

    // Counter, pending results and HI/LO
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_we <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else if (accept) begin
            case (op)
                MD_MULT, MD_MULTU: begin
                    cnt     <= MULT_LD;
                    pend_hi <= ar.hi;
                    pend_lo <= ar.lo;
                    pend_we <= 1'b1;
                end
                MD_DIV, MD_DIVU: begin
                    cnt     <= DIV_LD;
                    pend_hi <= ar.hi;
                    pend_lo <= ar.lo;
                    pend_we <= ~ar.div_zero;
                end
                MD_MTHI: hi <= src_a;
                MD_MTLO: lo <= src_a;
                default: ;
            endcase
        end else if (state == S_BUSY) begin
            cnt <= cnt - CNT_ONE;
            if (done && pend_we) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
        end
    end

endmodule

// File: doc/md_unit_ctrl.md
Name: md_unit_ctrl

Overview:
- Multi-cycle multiply/divide controller with HI/LO register pair, attached to the E stage of the 5-stage pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo commands from E, models fixed operation latency with a busy counter, and commits results to HI/LO on completion.
- Raises a stall request to the hazard controller whenever the D-stage instruction needs the unit while it is busy or being started.
- The pipeline reads HI and LO directly for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu (must be ≥1).
- DIV_CYCLES, 10, busy duration in cycles for div/divu (must be ≥1).
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  E stage issues a command this cycle (qualified by op).
- op  in  3  command code (MD_* constants).
- src_a  in  32  forwarded rs value from E.
- src_b  in  32  forwarded rt value from E.
- d_md_use  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- busy  out  1  operation in progress.
- stall_md  out  1  stall request to the hazard controller.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Decided interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset:
  - state=IDLE, cnt=0, busy=0, hi=0, lo=0, pending results=0.
  - Reset mid-operation aborts the operation. HI/LO are cleared and nothing is committed.
- States:
  - IDLE: unit is free.
  - BUSY: counting down an operation.
- Command acceptance: a command is accepted only in IDLE with start=1.
  - In BUSY, start is ignored and state is unchanged. The hazard controller guarantees no such issue occurs.
- mult/multu/div/divu, accepted at edge k:
  - Compute the result combinationally from src_a/src_b and capture it into pend_hi/pend_lo.
  - Load cnt with MULT_CYCLES or DIV_CYCLES and go to BUSY.
- BUSY: each edge decrements cnt.
  - At the edge where cnt==1: hi<=pend_hi, lo<=pend_lo, cnt<=0, go to IDLE.
  - busy is therefore high for exactly the latency in cycles: cycles k+1 .. k+LAT.
  - HI/LO hold their old values throughout BUSY.
- Arithmetic:
  - mult: signed 32×32→64 product; hi=[63:32], lo=[31:0].
  - multu: as mult, unsigned.
  - div: signed; lo=quotient, hi=remainder, with truncation toward zero (remainder takes the sign of the dividend).
  - divu: as div, unsigned.
  - Divide by zero: the full DIV_CYCLES busy period still runs, but HI/LO are not written (retain prior values).
  - Signed div 0x80000000 / -1: lo=0x80000000, hi=0.
- mthi/mtlo, accepted in IDLE:
  - hi<=src_a (mthi) or lo<=src_a (mtlo) at the next edge.
  - No busy period; state stays IDLE.
- op=MD_NONE or unused codes with start=1: no effect.
- busy = (state==BUSY); registered state, combinational decode.
- stall_md = d_md_use & (busy | (start & op∈{MULT,MULTU,DIV,DIVU})). Combinational, same cycle.
- mfhi/mflo in D therefore stalls until the cycle after completion, and sees the committed HI/LO.
- Simultaneous events:
  - Completion edge and a new start on the same edge cannot occur: start is only accepted in IDLE, and busy is still high on the completion cycle.
  - A start is accepted on the first IDLE cycle after completion.

Decomposition:
- Shared package md_defs holds:
  - op codes: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6;
  - state encoding: S_IDLE=0, S_BUSY=1;
  - default latency constants.
- One natural sub-module, md_arith: purely combinational 64-bit product and quotient/remainder, with a div-by-zero flag. The controller holds the FSM, counter and HI/LO registers.

Test Plan:
1. Reset, then mult src_a=0xFFFFFFFE (-2), src_b=3 → busy high exactly 5 cycles; afterwards hi=0xFFFFFFFF, lo=0xFFFFFFFA.
2. multu with the same operands → hi=0x00000002, lo=0xFFFFFFFA after 5 cycles.
3. div src_a=-7, src_b=2 → busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. Hold d_md_use=1 throughout → stall_md=1 on the start cycle and all 10 busy cycles, 0 on the following cycle.
4. mthi 0x12345678, then divu src_b=0 → busy 10 cycles; hi stays 0x12345678 and lo is unchanged.
5. mult started, reset asserted on the 3rd busy cycle → next cycle busy=0, hi=lo=0. A new mtlo 0xA5A5A5A5 then sets lo next edge.
6. start with MD_MULT while BUSY → ignored: busy count unchanged, and the original result commits at the original completion cycle.
